// File: rtl/kvt_proj_name_apb_regs_if.sv
// APB3 bus bundle between the requester and the register-bank completer.
interface kvt_proj_name_apb_regs_if #(
   parameter int ADDR_W = 8
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [31:0]       pwdata;
   logic              pready;
   logic [31:0]       prdata;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/kvt_proj_name_apb_regs.sv
// APB3 completer for the project control/status register bank.
// Map (paddr[3:0]): 0x0 ID (ro), 0x4 CTRL (rw), 0x8 SCRATCH (rw), 0xC ACC_CNT (ro).
// The state register records the phase the bus was in on the previous cycle,
// so the first penable=1 cycle after a setup beat is already an access cycle
// with wait count 0; WAIT_STATES=0 therefore completes in the classic 2 cycles.
module kvt_proj_name_apb_regs #(
   parameter int          ADDR_W      = 8,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'h4B56_0001,
   parameter logic [31:0] CTRL_RST    = 32'h0000_0000
) (
   input  logic                        clk,
   input  logic                        rst,
   kvt_proj_name_apb_regs_if.slave     apb,
   output logic [31:0]                 ctrl_o
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [3:0]  wcnt_reg, wcnt_next;
   logic [31:0] ctrl_reg, scratch_reg, acc_cnt_reg;

   logic [3:0]  offset;
   logic [3:0]  wcnt_cur;
   logic        in_access;
   logic        done;
   logic        err;
   logic [31:0] rd_mux;

   assign offset = apb.paddr[3:0];

   // Upper address bits take no part in decoding.
   if (ADDR_W > 4) begin : g_upper
      logic unused_upper;
      assign unused_upper = ^apb.paddr[ADDR_W-1:4];
   end

   // Decode the current access cycle from the state flops and the live request.
   always_comb begin
      wcnt_cur  = (state_reg == ACCESS) ? wcnt_reg : 4'd0;
      in_access = apb.psel && apb.penable &&
                  ((state_reg == SETUP) || (state_reg == ACCESS));
      done      = in_access && (wcnt_cur == WS);
      err       = (offset[1:0] != 2'b00) ||
                  (apb.pwrite && ((offset[3:2] == 2'b00) || (offset[3:2] == 2'b11)));
   end

   // Read mux over the four word registers.
   always_comb begin
      rd_mux = 32'd0;
      case (offset[3:2])
         2'b00:   rd_mux = ID_VALUE;
         2'b01:   rd_mux = ctrl_reg;
         2'b10:   rd_mux = scratch_reg;
         default: rd_mux = acc_cnt_reg;
      endcase
   end

   // Next-state logic: track setup/access phases, abort when psel drops.
   always_comb begin
      state_next = state_reg;
      wcnt_next  = wcnt_reg;
      case (state_reg)
         IDLE: begin
            if (apb.psel && !apb.penable) begin
               state_next = SETUP;
            end
            wcnt_next = 4'd0;
         end
         SETUP, ACCESS: begin
            if (!apb.psel) begin
               state_next = IDLE;
               wcnt_next  = 4'd0;
            end else if (!apb.penable) begin
               state_next = SETUP;
               wcnt_next  = 4'd0;
            end else if (done) begin
               state_next = IDLE;
               wcnt_next  = 4'd0;
            end else begin
               state_next = ACCESS;
               wcnt_next  = wcnt_cur + 4'd1;
            end
         end
         default: begin
            state_next = IDLE;
            wcnt_next  = 4'd0;
         end
      endcase
   end

   // FSM state and wait counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         wcnt_reg  <= 4'd0;
      end else begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
      end
   end

   // Register bank: commit legal writes and count every completed transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_reg    <= CTRL_RST;
         scratch_reg <= 32'd0;
         acc_cnt_reg <= 32'd0;
      end else if (done) begin
         acc_cnt_reg <= acc_cnt_reg + 32'd1;
         if (apb.pwrite && !err) begin
            case (offset[3:2])
               2'b01:   ctrl_reg    <= apb.pwdata;
               2'b10:   scratch_reg <= apb.pwdata;
               default: ;
            endcase
         end
      end
   end

   assign apb.pready  = done;
   assign apb.pslverr = done && err;
   assign apb.prdata  = (done && !err && !apb.pwrite) ? rd_mux : 32'd0;
   assign ctrl_o      = ctrl_reg;

endmodule

// File: tb/tb_kvt_proj_name_apb_regs.sv
// Bench for the APB register bank: one instance with no wait states and one
// with three wait states, sharing a single requester that targets one at a time.
module tb_kvt_proj_name_apb_regs;

   localparam logic [31:0] ID_VAL    = 32'h4B56_0001;
   localparam logic [31:0] CRST0     = 32'h0000_0000;
   localparam logic [31:0] CRST1     = 32'h1234_5678;
   localparam int          WS_OF [2] = '{0, 3};

   logic clk = 1'b0;
   logic rst0, rst1;
   always #5 clk = ~clk;

   // Shared requester signals; sel picks the instance.
   int          sel = 0;
   logic        m_psel = 1'b0, m_penable = 1'b0, m_pwrite = 1'b0;
   logic [7:0]  m_paddr = 8'h00;
   logic [31:0] m_pwdata = 32'd0;

   kvt_proj_name_apb_regs_if #(.ADDR_W(8)) apb0 ();
   kvt_proj_name_apb_regs_if #(.ADDR_W(8)) apb1 ();

   assign apb0.psel    = (sel == 0) ? m_psel : 1'b0;
   assign apb0.penable = (sel == 0) ? m_penable : 1'b0;
   assign apb0.pwrite  = m_pwrite;
   assign apb0.paddr   = m_paddr;
   assign apb0.pwdata  = m_pwdata;
   assign apb1.psel    = (sel == 1) ? m_psel : 1'b0;
   assign apb1.penable = (sel == 1) ? m_penable : 1'b0;
   assign apb1.pwrite  = m_pwrite;
   assign apb1.paddr   = m_paddr;
   assign apb1.pwdata  = m_pwdata;

   logic [31:0] ctrl0, ctrl1;

   kvt_proj_name_apb_regs #(.ADDR_W(8), .WAIT_STATES(0), .ID_VALUE(ID_VAL), .CTRL_RST(CRST0))
      dut0 (.clk(clk), .rst(rst0), .apb(apb0), .ctrl_o(ctrl0));
   kvt_proj_name_apb_regs #(.ADDR_W(8), .WAIT_STATES(3), .ID_VALUE(ID_VAL), .CTRL_RST(CRST1))
      dut1 (.clk(clk), .rst(rst1), .apb(apb1), .ctrl_o(ctrl1));

   logic        rdy, serr;
   logic [31:0] rdat, ctrl_sel;
   assign rdy      = (sel == 1) ? apb1.pready  : apb0.pready;
   assign serr     = (sel == 1) ? apb1.pslverr : apb0.pslverr;
   assign rdat     = (sel == 1) ? apb1.prdata  : apb0.prdata;
   assign ctrl_sel = (sel == 1) ? ctrl1 : ctrl0;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: register contents per instance.
   logic [31:0] ctrl_m [2];
   logic [31:0] scratch_m [2];
   logic [31:0] acc_m [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic model_reset(input int d);
      ctrl_m[d]    = (d == 1) ? CRST1 : CRST0;
      scratch_m[d] = 32'd0;
      acc_m[d]     = 32'd0;
   endtask

   // Applies the register-map rules to one completed transfer.
   task automatic model_xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                             output logic [31:0] erd, output logic eer);
      int off;
      off = int'(a) % 16;
      eer = (off % 4 != 0) || (wr && (off == 0 || off == 12));
      erd = 32'd0;
      if (!eer && !wr) begin
         if (off == 0)      erd = ID_VAL;
         else if (off == 4) erd = ctrl_m[d];
         else if (off == 8) erd = scratch_m[d];
         else               erd = acc_m[d];
      end
      if (!eer && wr) begin
         if (off == 4) ctrl_m[d] = wd;
         else          scratch_m[d] = wd;
      end
      acc_m[d] = acc_m[d] + 32'd1;
   endtask

   // Drives one APB transfer; paddr switches to a_late for wait-state cycles.
   task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [7:0] a_late, input bit b2b,
                       output logic [31:0] rd, output logic er, output int cyc);
      bit fin;
      @(posedge clk); #1;
      sel = d; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = a; m_pwdata = wd;
      @(negedge clk);
      check("setup pready", {31'd0, rdy}, 32'd0);
      @(posedge clk); #1;
      m_penable = 1'b1;
      cyc = 2;
      fin = 1'b0;
      rd = 32'd0;
      er = 1'b0;
      while (!fin) begin
         @(negedge clk);
         if (rdy) begin
            fin = 1'b1;
            rd  = rdat;
            er  = serr;
         end else if (cyc >= 40) begin
            n_total++;
            $display("FAIL pready timeout: got no pready after %0d cycles, expected %0d", cyc, 2 + WS_OF[d]);
            fin = 1'b1;
         end else begin
            @(posedge clk); #1;
            m_paddr = a_late;
            cyc++;
         end
      end
      if (!b2b) begin
         @(posedge clk); #1;
         m_psel = 1'b0; m_penable = 1'b0;
      end
   endtask

   // Transfer checked against the reference model.
   task automatic do_xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                          input logic [7:0] a_late, input bit b2b, input string tag);
      logic [31:0] rd, erd;
      logic er, eer;
      int cyc;
      xfer(d, wr, a, wd, a_late, b2b, rd, er, cyc);
      model_xfer(d, wr, (WS_OF[d] == 0) ? a : a_late, wd, erd, eer);
      $display("xfer %s d%0d %s a=%h wd=%h rd=%h err=%0d cyc=%0d", tag, d, wr ? "W" : "R", a, wd, rd, er, cyc);
      check({tag, " prdata"}, rd, erd);
      check({tag, " pslverr"}, {31'd0, er}, {31'd0, eer});
      check({tag, " cycles"}, cyc, 2 + WS_OF[d]);
      if (!b2b) check({tag, " ctrl_o"}, ctrl_sel, ctrl_m[d]);
   endtask

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
      logic [31:0] exp_ctrl;
   } vec_t;

   vec_t vecs [15];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, erd;
      logic er, eer;
      int cyc;
      bit b2b;
      logic [7:0] a, al;

      vecs[0]  = '{1'b0, 8'h00, 32'h0,         32'h4B56_0001, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 8'h04, 32'h0,         32'h0,         1'b0, 32'h0};
      vecs[2]  = '{1'b0, 8'h08, 32'h0,         32'h0,         1'b0, 32'h0};
      vecs[3]  = '{1'b0, 8'h0C, 32'h0,         32'd3,         1'b0, 32'h0};
      vecs[4]  = '{1'b1, 8'h08, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'h0};
      vecs[5]  = '{1'b1, 8'h04, 32'h0000_00A5, 32'h0,         1'b0, 32'hA5};
      vecs[6]  = '{1'b0, 8'h08, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'hA5};
      vecs[7]  = '{1'b1, 8'h00, 32'h1111_1111, 32'h0,         1'b1, 32'hA5};
      vecs[8]  = '{1'b1, 8'h0C, 32'h2222_2222, 32'h0,         1'b1, 32'hA5};
      vecs[9]  = '{1'b0, 8'h06, 32'h0,         32'h0,         1'b1, 32'hA5};
      vecs[10] = '{1'b0, 8'h04, 32'h0,         32'hA5,        1'b0, 32'hA5};
      vecs[11] = '{1'b0, 8'hF8, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'hA5};
      vecs[12] = '{1'b0, 8'h0C, 32'h0,         32'd12,        1'b0, 32'hA5};
      vecs[13] = '{1'b1, 8'h09, 32'h3333_3333, 32'h0,         1'b1, 32'hA5};
      vecs[14] = '{1'b0, 8'h0C, 32'h0,         32'd14,        1'b0, 32'hA5};

      // Reset
      rst0 = 1'b1; rst1 = 1'b1;
      model_reset(0); model_reset(1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset ctrl_o d0", ctrl0, CRST0);
      check("reset ctrl_o d1", ctrl1, CRST1);
      check("reset pready", {31'd0, apb0.pready | apb1.pready}, 32'd0);
      check("reset pslverr", {31'd0, apb0.pslverr | apb1.pslverr}, 32'd0);
      check("reset prdata", apb0.prdata | apb1.prdata, 32'd0);
      @(posedge clk); #1;
      rst0 = 1'b0; rst1 = 1'b0;

      // Directed table on the zero-wait instance
      for (int i = 0; i < 15; i++) begin
         xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].addr, 1'b0, rd, er, cyc);
         model_xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, erd, eer);
         $display("xfer vec%0d d0 %s a=%h wd=%h rd=%h err=%0d cyc=%0d", i, vecs[i].wr ? "W" : "R",
                  vecs[i].addr, vecs[i].wdata, rd, er, cyc);
         check($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d pslverr", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
         check($sformatf("vec%0d cycles", i), cyc, 2);
         check($sformatf("vec%0d ctrl_o", i), ctrl0, vecs[i].exp_ctrl);
      end

      // Back-to-back writes, then read both back
      do_xfer(0, 1'b1, 8'h04, 32'h5A5A_0000, 8'h04, 1'b1, "b2b wr ctrl");
      do_xfer(0, 1'b1, 8'h08, 32'h0123_4567, 8'h08, 1'b0, "b2b wr scratch");
      check("b2b ctrl_o", ctrl0, 32'h5A5A_0000);
      do_xfer(0, 1'b0, 8'h04, 32'h0, 8'h04, 1'b1, "b2b rd ctrl");
      do_xfer(0, 1'b0, 8'h08, 32'h0, 8'h08, 1'b0, "b2b rd scratch");

      // penable without a setup beat is ignored
      @(posedge clk); #1;
      sel = 0; m_psel = 1'b1; m_penable = 1'b1; m_pwrite = 1'b1; m_paddr = 8'h04; m_pwdata = 32'hBAD0_BAD0;
      repeat (3) begin
         @(negedge clk);
         check("idle penable pready", {31'd0, rdy}, 32'd0);
         @(posedge clk); #1;
      end
      m_psel = 1'b0; m_penable = 1'b0;
      do_xfer(0, 1'b0, 8'h04, 32'h0, 8'h04, 1'b0, "idle penable ctrl");
      do_xfer(0, 1'b0, 8'h0C, 32'h0, 8'h0C, 1'b0, "idle penable acc");

      // Wait states, including paddr changing during the waits
      do_xfer(1, 1'b1, 8'h08, 32'hCAFE_F00D, 8'h08, 1'b0, "ws wr scratch");
      do_xfer(1, 1'b0, 8'h00, 32'h0, 8'h00, 1'b0, "ws rd id");
      xfer(1, 1'b0, 8'h00, 32'h0, 8'h08, 1'b0, rd, er, cyc);
      model_xfer(1, 1'b0, 8'h08, 32'h0, erd, eer);
      $display("xfer ws late-addr d1 R a=00->08 rd=%h err=%0d cyc=%0d", rd, er, cyc);
      check("ws late addr prdata", rd, 32'hCAFE_F00D);
      check("ws late addr cycles", cyc, 5);

      // Abort: psel drops after one wait cycle
      @(posedge clk); #1;
      sel = 1; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 8'h04; m_pwdata = 32'hDEAD_0000;
      @(negedge clk);
      check("abort setup pready", {31'd0, rdy}, 32'd0);
      @(posedge clk); #1;
      m_penable = 1'b1;
      @(negedge clk);
      check("abort wait pready", {31'd0, rdy}, 32'd0);
      @(posedge clk); #1;
      m_psel = 1'b0; m_penable = 1'b0;
      @(negedge clk);
      check("abort drop pready", {31'd0, rdy}, 32'd0);
      $display("xfer abort d1 W a=04 wd=DEAD0000 dropped");
      check("abort ctrl_o", ctrl1, ctrl_m[1]);
      do_xfer(1, 1'b0, 8'h04, 32'h0, 8'h04, 1'b0, "abort rd ctrl");
      do_xfer(1, 1'b0, 8'h0C, 32'h0, 8'h0C, 1'b0, "abort rd acc");

      // Randomised traffic, zero-wait instance
      for (int i = 0; i < 100; i++) begin
         a  = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
         b2b = (i == 99) ? 1'b0 : 1'($urandom_range(0, 1));
         do_xfer(0, 1'($urandom_range(0, 1)), a, $urandom, a, b2b, $sformatf("rnd0_%0d", i));
      end

      // Randomised traffic, wait-state instance
      for (int i = 0; i < 60; i++) begin
         a  = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
         al = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
         b2b = (i == 59) ? 1'b0 : 1'($urandom_range(0, 1));
         do_xfer(1, 1'($urandom_range(0, 1)), a, $urandom, al, b2b, $sformatf("rnd1_%0d", i));
      end

      // ACC_CNT wrap: preload all-ones, read returns pre-increment then 0
      @(negedge clk);
      force dut0.acc_cnt_reg = 32'hFFFF_FFFF;
      #1;
      release dut0.acc_cnt_reg;
      acc_m[0] = 32'hFFFF_FFFF;
      do_xfer(0, 1'b0, 8'h0C, 32'h0, 8'h0C, 1'b0, "wrap rd acc max");
      do_xfer(0, 1'b0, 8'h0C, 32'h0, 8'h0C, 1'b0, "wrap rd acc zero");

      // Reset during a CTRL write's wait state
      do_xfer(1, 1'b1, 8'h04, 32'h0F0F_0F0F, 8'h04, 1'b0, "pre-rst wr ctrl");
      @(posedge clk); #1;
      sel = 1; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 8'h04; m_pwdata = 32'hFFFF_0000;
      @(posedge clk); #1;
      m_penable = 1'b1;
      @(negedge clk);
      #2;
      rst1 = 1'b1;
      #1;
      check("midrst ctrl_o async", ctrl1, CRST1);
      check("midrst pready", {31'd0, rdy}, 32'd0);
      @(posedge clk); #1;
      rst1 = 1'b0;
      m_psel = 1'b0; m_penable = 1'b0;
      model_reset(1);
      $display("xfer midrst d1 W a=04 wd=FFFF0000 reset");
      @(negedge clk);
      check("post-rst ctrl_o", ctrl1, CRST1);
      do_xfer(1, 1'b0, 8'h04, 32'h0, 8'h04, 1'b0, "post-rst rd ctrl");
      do_xfer(1, 1'b0, 8'h0C, 32'h0, 8'h0C, 1'b0, "post-rst rd acc");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
